data_island_packet_assembler: RTL and testbench

- Downstream consumer of the packet generators (audio clock regeneration, audio sample, infoframes).
- Takes one selected packet as header[23:0] plus four 56-bit subpackets.
- Appends HDMI BCH parity: BCH(32,24) on the header, BCH(64,56) on each subpacket.
- Serialises the packet into 32 beats of 9-bit data-island payload for the TERC4 encoders during the data island period.

---
 rtl/data_island_packet_assembler_if.sv | 27 ++
 rtl/data_island_packet_assembler.sv | 106 ++++++++++
 tb/tb_data_island_packet_assembler.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/data_island_packet_assembler_if.sv
`default_nettype none
// ============================================================================
//  Module   : data_island_packet_assembler_if
//  Purpose  : Packet input and serialized payload bus of the data island
//             packet assembler.
//  Revision : 1.0  initial release
// ============================================================================
interface data_island_packet_assembler_if;
  logic         data_island_period;
  logic [23:0]  header;
  logic [223:0] sub;
  logic [8:0]   packet_data;
  logic         packet_data_valid;
  logic [4:0]   counter;
  logic         packet_done;

  modport master (
    output data_island_period, header, sub,
    input  packet_data, packet_data_valid, counter, packet_done
  );

  modport slave (
    input  data_island_period, header, sub,
    output packet_data, packet_data_valid, counter, packet_done
  );
endinterface
`default_nettype wire

// File: rtl/data_island_packet_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : data_island_packet_assembler
//  Purpose  : Adds BCH parity to one HDMI data island packet and serializes it
//             into 32 beats of 9-bit TERC4 payload.
//  Revision : 1.0  initial release
// ============================================================================
module data_island_packet_assembler #(
  parameter logic [7:0] ECC_POLY = 8'b1000_0011
) (
  input logic clk_pixel,
  input logic reset,
  data_island_packet_assembler_if.slave bus
);

  localparam logic [4:0] c_HDR_DATA_BEATS = 5'd24;
  localparam logic [4:0] c_SUB_DATA_BEATS = 5'd28;
  localparam logic [4:0] c_LAST_BEAT      = 5'd31;

  logic [4:0]      r_b;
  logic [23:0]     r_hdr_sh;
  logic [223:0]    r_sub_sh;
  logic [7:0]      r_ecc_h;
  logic [3:0][7:0] r_ecc_s;

  logic [23:0]     w_hdr;
  logic [223:0]    w_sub;
  logic            w_hdr_bit;
  logic [7:0]      w_ecc_h_next;
  logic            w_hdr_out;
  logic [3:0][7:0] w_ecc_s_next;
  logic [3:0][1:0] w_sub_out;
  logic [8:0]      w_beat;

  function automatic logic [7:0] f_ecc_step(input logic [7:0] ecc, input logic d);
    return {1'b0, ecc[7:1]} ^ ({8{ecc[0] ^ d}} & ECC_POLY);
  endfunction

  // Beat 0 serializes straight from the live inputs while they are captured.
  assign w_hdr = (r_b == 5'd0) ? bus.header : r_hdr_sh;
  assign w_sub = (r_b == 5'd0) ? bus.sub    : r_sub_sh;

  assign w_hdr_bit    = w_hdr[r_b];
  assign w_ecc_h_next = f_ecc_step((r_b == 5'd0) ? 8'h00 : r_ecc_h, w_hdr_bit);
  // On parity beats 24..31 the low three bits of b are exactly b-24.
  assign w_hdr_out    = (r_b < c_HDR_DATA_BEATS) ? w_hdr_bit : r_ecc_h[r_b[2:0]];

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [55:0] w_lane;
    logic [1:0]  w_data;
    logic [7:0]  w_mid;

    assign w_lane = w_sub[gi*56 +: 56];
    assign w_data = w_lane[{r_b, 1'b0} +: 2];
    assign w_mid  = f_ecc_step((r_b == 5'd0) ? 8'h00 : r_ecc_s[gi], w_data[0]);
    assign w_ecc_s_next[gi] = f_ecc_step(w_mid, w_data[1]);
    assign w_sub_out[gi] = (r_b < c_SUB_DATA_BEATS) ? w_data
                                                    : r_ecc_s[gi][{r_b[1:0], 1'b0} +: 2];
  end

  always_comb begin
    w_beat    = '0;
    w_beat[0] = w_hdr_out;
    for (int i = 0; i < 4; i++) begin
      w_beat[1+i] = w_sub_out[i][0];
      w_beat[5+i] = w_sub_out[i][1];
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_b                   <= '0;
      r_hdr_sh              <= '0;
      r_sub_sh              <= '0;
      r_ecc_h               <= '0;
      r_ecc_s               <= '0;
      bus.packet_data       <= '0;
      bus.packet_data_valid <= 1'b0;
      bus.counter           <= '0;
      bus.packet_done       <= 1'b0;
    end else if (!bus.data_island_period) begin
      // Leaving the island (normally or by abort) discards any partial packet.
      r_b                   <= '0;
      r_ecc_h               <= '0;
      r_ecc_s               <= '0;
      bus.packet_data       <= '0;
      bus.packet_data_valid <= 1'b0;
      bus.counter           <= '0;
      bus.packet_done       <= 1'b0;
    end else begin
      r_b <= r_b + 5'd1;
      if (r_b == 5'd0) begin
        r_hdr_sh <= bus.header;
        r_sub_sh <= bus.sub;
      end
      if (r_b < c_HDR_DATA_BEATS) r_ecc_h <= w_ecc_h_next;
      if (r_b < c_SUB_DATA_BEATS) r_ecc_s <= w_ecc_s_next;
      bus.packet_data       <= w_beat;
      bus.packet_data_valid <= 1'b1;
      bus.counter           <= r_b;
      bus.packet_done       <= (r_b == c_LAST_BEAT);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_island_packet_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_island_packet_assembler
//  Purpose  : Randomized self-checking bench against a packet-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_island_packet_assembler;

  logic clk_pixel = 1'b0;
  logic reset     = 1'b1;

  data_island_packet_assembler_if bus();

  data_island_packet_assembler #(.ECC_POLY(8'b1000_0011)) dut (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .bus       (bus)
  );

  always #5 clk_pixel = ~clk_pixel;

  int         n_tests   = 0;
  int         n_fail    = 0;
  int         m_b       = 0;
  int         done_exp  = 0;
  int         done_seen = 0;
  logic [8:0] m_pkt [32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] bch(input logic [55:0] bits, input int n);
    logic [7:0] e;
    logic       fb;
    e = 8'h00;
    for (int i = 0; i < n; i++) begin
      fb = e[0] ^ bits[i];
      e  = {1'b0, e[7:1]} ^ ({8{fb}} & 8'b1000_0011);
    end
    return e;
  endfunction

  // Whole packet as codewords: header {ecc,hdr} 1 bit/beat, subpackets {ecc,sub} 2 bits/beat.
  task automatic build_packet(input logic [23:0] h, input logic [223:0] s);
    logic [31:0] hcw;
    logic [63:0] scw [4];
    logic [55:0] sp;
    hcw = {bch({32'b0, h}, 24), h};
    for (int i = 0; i < 4; i++) begin
      sp     = s[i*56 +: 56];
      scw[i] = {bch(sp, 56), sp};
    end
    for (int k = 0; k < 32; k++) begin
      m_pkt[k][0] = hcw[k];
      for (int i = 0; i < 4; i++) begin
        m_pkt[k][1+i] = scw[i][2*k];
        m_pkt[k][5+i] = scw[i][2*k+1];
      end
    end
  endtask

  task automatic step();
    logic [8:0] e_data;
    logic       e_valid;
    logic [4:0] e_cnt;
    logic       e_done;
    e_data = '0; e_valid = 1'b0; e_cnt = '0; e_done = 1'b0;
    if (reset) begin
      m_b = 0;
    end else if (bus.data_island_period) begin
      if (m_b == 0) build_packet(bus.header, bus.sub);
      e_data  = m_pkt[m_b];
      e_valid = 1'b1;
      e_cnt   = m_b[4:0];
      e_done  = (m_b == 31);
      m_b     = (m_b + 1) % 32;
    end else begin
      m_b = 0;
    end
    @(posedge clk_pixel);
    #1;
    if (e_done) done_exp++;
    if (bus.packet_done === 1'b1) done_seen++;
    check("data",  bus.packet_data,       e_data);
    check("valid", bus.packet_data_valid, e_valid);
    check("count", bus.counter,           e_cnt);
    check("done",  bus.packet_done,       e_done);
  endtask

  task automatic rand_inputs();
    bus.header = $urandom;
    for (int i = 0; i < 7; i++) bus.sub[i*32 +: 32] = $urandom;
  endtask

  task automatic idle(input int n);
    bus.data_island_period = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_beats(input int n);
    bus.data_island_period = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  logic [55:0] acr_sub;

  initial begin
    bus.data_island_period = 1'b0;
    bus.header = '0;
    bus.sub    = '0;
    reset      = 1'b1;
    step();
    step();
    reset = 1'b0;
    idle(2);

    // All-zero packet: zero parity, every beat 9'h000.
    bus.data_island_period = 1'b1;
    for (int i = 0; i < 32; i++) begin
      step();
      check("zero_beat", bus.packet_data, 32'h0);
    end
    idle(2);

    // ACR packet: N=6144, CTS=25200 in every subpacket.
    acr_sub    = {8'h00, 8'h18, 8'h00, 8'h70, 8'h62, 8'h00, 8'h00};
    bus.header = 24'h000001;
    for (int i = 0; i < 4; i++) bus.sub[i*56 +: 56] = acr_sub;
    bus.data_island_period = 1'b1;
    step();
    check("acr_b0_bit0", bus.packet_data[0], 32'h1);
    run_beats(31);
    idle(2);

    // Inputs scrambled from beat 1 on; the shadow copy must be used.
    rand_inputs();
    bus.data_island_period = 1'b1;
    step();
    for (int i = 1; i < 32; i++) begin
      rand_inputs();
      step();
    end
    idle(2);

    // Two back-to-back packets with a 31->0 wrap and no gap.
    rand_inputs();
    bus.data_island_period = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (i == 32) rand_inputs();
      step();
    end
    idle(2);

    // Abort at beat 13, four idle cycles, then a fresh packet.
    rand_inputs();
    run_beats(13);
    idle(4);
    rand_inputs();
    run_beats(32);
    idle(2);

    // Reset during beat 20, then a full packet.
    rand_inputs();
    run_beats(20);
    reset = 1'b1;
    step();
    reset = 1'b0;
    rand_inputs();
    run_beats(32);
    idle(2);

    // Random traffic with occasional gaps and resets.
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      bus.data_island_period = ($urandom_range(0, 9) != 0);
      reset = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0;
    idle(2);

    check("done_pulses", done_seen, done_exp);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
